// File: rtl/flit_inject_fifo.sv
// flit_inject_fifo: first-word fall-through injection FIFO between a
// non-stallable upstream flit source and a router local input port.
// Full-and-not-popping arrivals are dropped and flagged; accepted flits are
// checked for head/body/tail framing.
// Optional macro INJECT_STATS_EN: when defined, pkt_cnt/drop_cnt are live
// saturating counters; otherwise both outputs are tied to zero.
module flit_inject_fifo #(
  parameter int DATA_W = 20,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              clr,
  output logic              ovf_err,
  output logic              fmt_err,
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       drop_cnt
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  // flit type encodings from the two top bits
  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_TAIL   = 2'b01;
  localparam logic [1:0] FT_HEAD   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PKT  = 1'b1;

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [0:0]       st_q, st_d;
  logic             ovf_err_q, ovf_err_d;
  logic             fmt_err_q, fmt_err_d;

  logic       push, pop, drop;
  logic       pkt_done, fmt_bad;
  logic [1:0] ftype;

  // outputs come straight from registered state; no input-to-output path
  assign out_valid = (cnt_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign ovf_err   = ovf_err_q;
  assign fmt_err   = fmt_err_q;

  // a pop frees a slot in the same cycle, so a full FIFO can still accept
  assign pop   = out_valid & out_ready;
  assign push  = in_valid & ((cnt_q != FULL) | pop);
  assign drop  = in_valid & ~push;
  assign ftype = in_data[DATA_W-1 -: 2];

  // storage and pointer/count update; pointers wrap since DEPTH is 2^n
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // framing FSM, advanced only by accepted flits
  always_comb begin
    st_d     = st_q;
    pkt_done = 1'b0;
    fmt_bad  = 1'b0;
    if (push) begin
      if (st_q == ST_IDLE) begin
        case (ftype)
          FT_HEAD:   st_d = ST_PKT;
          FT_SINGLE: pkt_done = 1'b1;
          default:   fmt_bad = 1'b1;   // body/tail with no open packet
        endcase
      end else begin
        case (ftype)
          FT_BODY:   st_d = ST_PKT;
          FT_TAIL: begin
            st_d     = ST_IDLE;
            pkt_done = 1'b1;
          end
          default:   fmt_bad = 1'b1;   // head or single inside a packet
        endcase
      end
    end
  end

  // sticky error flags; clr wins over a same-cycle set
  always_comb begin
    ovf_err_d = ovf_err_q | drop;
    fmt_err_d = fmt_err_q | fmt_bad;
    if (clr) begin
      ovf_err_d = 1'b0;
      fmt_err_d = 1'b0;
    end
  end

  // storage is not reset; out_data is don't-care while out_valid is low
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // control state with asynchronous reset
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      st_q      <= ST_IDLE;
      ovf_err_q <= 1'b0;
      fmt_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      st_q      <= st_d;
      ovf_err_q <= ovf_err_d;
      fmt_err_q <= fmt_err_d;
    end
  end

`ifdef INJECT_STATS_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // saturating statistics counters; clr wins over a same-cycle increment
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (pkt_done && pkt_cnt_q != 16'hFFFF) pkt_cnt_d  = pkt_cnt_q + 16'd1;
    if (drop && drop_cnt_q != 16'hFFFF)    drop_cnt_d = drop_cnt_q + 16'd1;
    if (clr) begin
      pkt_cnt_d  = '0;
      drop_cnt_d = '0;
    end
  end

  // counter registers
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;
`else
  // counters compiled out; packet-complete strobe has no consumer
  logic stats_unused;
  assign stats_unused = pkt_done;
  assign pkt_cnt      = '0;
  assign drop_cnt     = '0;
`endif

endmodule

// File: tb/tb_flit_inject_fifo.sv
// Directed bench for flit_inject_fifo (DATA_W=20, DEPTH=8). Inputs change
// 1ns after a rising edge; outputs are checked at that same point, i.e. the
// state produced by the preceding edge.
module tb_flit_inject_fifo;

`ifdef INJECT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        RST;
  logic [19:0] in_data;
  logic        in_valid;
  logic [19:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        clr;
  logic        ovf_err;
  logic        fmt_err;
  logic [15:0] pkt_cnt;
  logic [15:0] drop_cnt;

  int checks = 0;
  int passes = 0;

  flit_inject_fifo #(.DATA_W(20), .DEPTH(8)) dut (
    .clk(clk), .RST(RST), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .clr(clr), .ovf_err(ovf_err), .fmt_err(fmt_err),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [15:0] st(input int n);
    return STATS ? 16'(n) : 16'd0;
  endfunction

  logic [19:0] fl [0:9];

  initial begin
    RST = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_ovf", 32'(ovf_err), 32'd0);
    chk("rst_fmt", 32'(fmt_err), 32'd0);
    chk("rst_pkt", 32'(pkt_cnt), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    step();
    RST = 1'b0;
    step();

    // in-order delivery, 1-cycle latency
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 20'h80001;
    chk("ord_idle_valid", 32'(out_valid), 32'd0);
    step();
    chk("ord_v0", 32'(out_valid), 32'd1);
    chk("ord_d0", 32'(out_data), 32'h80001);
    in_data = 20'h00002;
    step();
    chk("ord_d1", 32'(out_data), 32'h00002);
    in_data = 20'h40003;
    step();
    chk("ord_d2", 32'(out_data), 32'h40003);
    in_valid = 1'b0;
    step();
    chk("ord_empty", 32'(out_valid), 32'd0);
    chk("ord_pkt", 32'(pkt_cnt), 32'(st(1)));
    chk("ord_fmt", 32'(fmt_err), 32'd0);

    // overflow: 10 flits into 8 entries, no drain
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) fl[i] = (i == 0) ? 20'h80010 : 20'h00010 + 20'(i);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = fl[i];
      step();
    end
    in_valid = 1'b0;
    chk("ovf_hold_data", 32'(out_data), 32'h80010);
    chk("ovf_flag", 32'(ovf_err), 32'd1);
    chk("ovf_drop", 32'(drop_cnt), 32'(st(2)));
    chk("ovf_fmt", 32'(fmt_err), 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("ovf_drain_v%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("ovf_drain_d%0d", k), 32'(out_data), 32'(fl[k]));
      step();
    end
    chk("ovf_drained", 32'(out_valid), 32'd0);

    // full + same-cycle pop: accepted, no drop (FSM still inside a packet)
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 20'h00020 + 20'(i);
      step();
    end
    out_ready = 1'b1; in_valid = 1'b1; in_data = 20'h40030;
    step();
    in_valid = 1'b0;
    chk("fullpop_drop", 32'(drop_cnt), 32'(st(2)));
    chk("fullpop_pkt", 32'(pkt_cnt), 32'(st(2)));
    for (int k = 1; k < 9; k++) begin
      chk($sformatf("fullpop_d%0d", k), 32'(out_data),
          (k == 8) ? 32'h40030 : 32'h00020 + 32'(k));
      step();
    end
    chk("fullpop_empty", 32'(out_valid), 32'd0);
    chk("fullpop_fmt", 32'(fmt_err), 32'd0);

    // clr zeroes flags and counters
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_ovf", 32'(ovf_err), 32'd0);
    chk("clr_drop", 32'(drop_cnt), 32'd0);
    chk("clr_pkt", 32'(pkt_cnt), 32'd0);

    // format error: body from IDLE still delivered
    in_valid = 1'b1; in_data = 20'h00005;
    step();
    chk("fmt_set", 32'(fmt_err), 32'd1);
    chk("fmt_deliv", 32'(out_data), 32'h00005);
    in_data = 20'hC0007;
    step();
    chk("single_d", 32'(out_data), 32'hC0007);
    chk("single_pkt", 32'(pkt_cnt), 32'(st(1)));
    // clr beats a same-cycle packet completion
    in_data = 20'hC0008; clr = 1'b1;
    step();
    in_valid = 1'b0; clr = 1'b0;
    chk("clrpri_fmt", 32'(fmt_err), 32'd0);
    chk("clrpri_pkt", 32'(pkt_cnt), 32'd0);
    chk("clrpri_d", 32'(out_data), 32'hC0008);
    step();
    chk("clrpri_empty", 32'(out_valid), 32'd0);

    // reset mid-packet
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 20'h80009; step();
    in_data = 20'h0000A; step();
    in_data = 20'h0000B; step();
    in_valid = 1'b0;
    chk("midrst_pre", 32'(out_valid), 32'd1);
    #2 RST = 1'b1;
    #1;
    chk("midrst_async", 32'(out_valid), 32'd0);
    step();
    RST = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 20'h4000C;
    step();
    in_valid = 1'b0;
    chk("midrst_fmt", 32'(fmt_err), 32'd1);
    chk("midrst_d", 32'(out_data), 32'h4000C);
    chk("midrst_pkt", 32'(pkt_cnt), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // safety net: never hang
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
